// File: rtl/stall_scoreboard_if.sv
// Handshake bundle between the PE write-back/operand-fetch stages and stall_scoreboard.
// master = pipeline side driving requests; slave = the scoreboard.
interface stall_scoreboard_if #(
  parameter int CONFIG_BIT = 4,
  parameter int NUM_RD     = 2
);
  localparam int DEPTH = 1 << CONFIG_BIT;

  logic                         wr_en;
  logic [CONFIG_BIT-1:0]        wr_addr;
  logic [NUM_RD-1:0]            rd_req;
  logic [NUM_RD*CONFIG_BIT-1:0] rd_addr;
  logic [NUM_RD-1:0]            rd_last;
  logic                         wr_ok;
  logic                         wr_stall;
  logic [NUM_RD-1:0]            rd_ok;
  logic [NUM_RD-1:0]            rd_stall;
  logic [DEPTH-1:0]             valid_map;
  logic [CONFIG_BIT:0]          occupancy;
  logic                         deadlock;

  modport master (
    output wr_en, wr_addr, rd_req, rd_addr, rd_last,
    input  wr_ok, wr_stall, rd_ok, rd_stall, valid_map, occupancy, deadlock
  );

  modport slave (
    input  wr_en, wr_addr, rd_req, rd_addr, rd_last,
    output wr_ok, wr_stall, rd_ok, rd_stall, valid_map, occupancy, deadlock
  );
endinterface

// File: rtl/stall_scoreboard.sv
// Per-entry valid scoreboard granting/stalling one write and NUM_RD reads per cycle.
// Optional macro SB_WR_FWD_EN: forward a same-cycle granted write to readers.

// One read channel: hit/grant, its clear contribution and its stall timeout counter.
module stall_scoreboard_lane #(
  parameter int CONFIG_BIT = 4,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [CONFIG_BIT-1:0] i_addr,
  input  logic                  i_req,
  input  logic                  i_last,
  input  logic                  i_wr_ok,
  input  logic [CONFIG_BIT-1:0] i_wr_addr,
  output logic                  o_ok,
  output logic                  o_stall,
  output logic [DEPTH-1:0]      o_clr,
  output logic                  o_fwd_kill,
  output logic                  o_at_limit
);
  localparam logic [TIMEOUT_W-1:0] LIMIT = {TIMEOUT_W{1'b1}};

  logic                 w_hit_reg;
  logic                 w_fwd;
  logic                 w_hit;
  logic [TIMEOUT_W-1:0] r_cnt;

  assign w_hit_reg = i_valid[i_addr];

`ifdef SB_WR_FWD_EN
  assign w_fwd = i_wr_ok & (i_wr_addr == i_addr);
`else
  logic w_unused;
  assign w_unused = &{1'b0, i_wr_ok, i_wr_addr};
  assign w_fwd    = 1'b0;
`endif

  assign w_hit   = w_hit_reg | w_fwd;
  assign o_ok    = i_rst_n & i_req & w_hit;
  assign o_stall = i_rst_n & i_req & ~w_hit;

  // Only registered hits feed the write-grant clear, so wr_ok never loops through forwarding.
  assign o_clr      = (i_rst_n & i_req & w_hit_reg & i_last) ? (DEPTH'(1) << i_addr) : '0;
  assign o_fwd_kill = o_ok & i_last & w_fwd & ~w_hit_reg;
  assign o_at_limit = (r_cnt == LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)          r_cnt <= '0;
    else if (!o_stall)     r_cnt <= '0;
    else if (!o_at_limit)  r_cnt <= r_cnt + 1'b1;
  end
endmodule

module stall_scoreboard #(
  parameter int CONFIG_BIT = 4,
  parameter int NUM_RD     = 2,
  parameter int TIMEOUT_W  = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  stall_scoreboard_if.slave sb
);
  localparam int DEPTH = 1 << CONFIG_BIT;

  logic [DEPTH-1:0]               r_valid;
  logic [CONFIG_BIT:0]            r_occ;
  logic                           r_deadlock;

  logic [NUM_RD-1:0][DEPTH-1:0]   w_clr_lane;
  logic [NUM_RD-1:0]              w_fwd_kill;
  logic [NUM_RD-1:0]              w_at_limit;
  logic [NUM_RD-1:0]              w_rd_ok;
  logic [NUM_RD-1:0]              w_rd_stall;
  logic [DEPTH-1:0]               w_clr;
  logic [CONFIG_BIT:0]            w_pop;
  logic                           w_wr_ok;
  logic                           w_set;
  logic [DEPTH-1:0]               w_valid_nxt;
  logic [CONFIG_BIT:0]            w_occ_nxt;

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_lane
      stall_scoreboard_lane #(
        .CONFIG_BIT(CONFIG_BIT), .DEPTH(DEPTH), .TIMEOUT_W(TIMEOUT_W)
      ) u_lane (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (r_valid),
        .i_addr    (sb.rd_addr[g*CONFIG_BIT +: CONFIG_BIT]),
        .i_req     (sb.rd_req[g]),
        .i_last    (sb.rd_last[g]),
        .i_wr_ok   (w_wr_ok),
        .i_wr_addr (sb.wr_addr),
        .o_ok      (w_rd_ok[g]),
        .o_stall   (w_rd_stall[g]),
        .o_clr     (w_clr_lane[g]),
        .o_fwd_kill(w_fwd_kill[g]),
        .o_at_limit(w_at_limit[g])
      );
    end
  endgenerate

  // Channels clearing the same entry collapse into one bit, so popcount counts it once.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_RD; i++) w_clr = w_clr | w_clr_lane[i];
    w_pop = '0;
    for (int i = 0; i < DEPTH; i++) w_pop = w_pop + (CONFIG_BIT+1)'(w_clr[i]);
  end

  assign w_wr_ok = i_rst_n & sb.wr_en & (~r_valid[sb.wr_addr] | w_clr[sb.wr_addr]);
  // A forwarded final read consumes the new entry before it is ever stored.
  assign w_set   = w_wr_ok & ~(|w_fwd_kill);

  assign w_valid_nxt = (r_valid & ~w_clr) | (w_set ? (DEPTH'(1) << sb.wr_addr) : '0);
  assign w_occ_nxt   = r_occ - w_pop + {{CONFIG_BIT{1'b0}}, w_set};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid    <= '0;
      r_occ      <= '0;
      r_deadlock <= 1'b0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_occ      <= w_occ_nxt;
      r_deadlock <= r_deadlock | (|w_at_limit);
    end
  end

  assign sb.wr_ok     = w_wr_ok;
  assign sb.wr_stall  = i_rst_n & sb.wr_en & ~w_wr_ok;
  assign sb.rd_ok     = w_rd_ok;
  assign sb.rd_stall  = w_rd_stall;
  assign sb.valid_map = r_valid;
  assign sb.occupancy = r_occ;
  assign sb.deadlock  = r_deadlock;
endmodule

// File: tb/tb_stall_scoreboard.sv
// Directed bench for stall_scoreboard (CONFIG_BIT=4, NUM_RD=2, TIMEOUT_W=8).
module tb_stall_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stall_scoreboard_if #(.CONFIG_BIT(4), .NUM_RD(2)) sb ();

  stall_scoreboard #(.CONFIG_BIT(4), .NUM_RD(2), .TIMEOUT_W(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .sb     (sb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.wr_en = 1'b0; sb.wr_addr = '0;
    sb.rd_req = '0; sb.rd_addr = '0; sb.rd_last = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    sb.wr_en = 1'b1; sb.wr_addr = 4'd1; sb.rd_req = 2'b11;
    tick();
    n_chk++; if (sb.wr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ok: got %b exp 0", sb.wr_ok); end
    n_chk++; if (sb.wr_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stall: got %b exp 0", sb.wr_stall); end
    n_chk++; if ({sb.rd_ok, sb.rd_stall} !== 4'b0) begin n_fail++; $display("FAIL reset_rd: got ok=%b stall=%b exp 00/00", sb.rd_ok, sb.rd_stall); end
    n_chk++; if (sb.valid_map !== 16'h0) begin n_fail++; $display("FAIL reset_valid: got %h exp 0000", sb.valid_map); end
    n_chk++; if (sb.occupancy !== 5'd0) begin n_fail++; $display("FAIL reset_occ: got %0d exp 0", sb.occupancy); end
    n_chk++; if (sb.deadlock !== 1'b0) begin n_fail++; $display("FAIL reset_deadlock: got %b exp 0", sb.deadlock); end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_deadlock();
    sb.rd_req = 2'b11; sb.rd_addr = {4'd3, 4'd3};
    #2;
    n_chk++; if (sb.rd_stall !== 2'b11) begin n_fail++; $display("FAIL dl_stall: got %b exp 11", sb.rd_stall); end
    n_chk++; if (sb.rd_ok !== 2'b00) begin n_fail++; $display("FAIL dl_ok: got %b exp 00", sb.rd_ok); end
    repeat (255) tick();
    n_chk++; if (sb.deadlock !== 1'b0) begin n_fail++; $display("FAIL dl_early: got %b exp 0 after 255 stalls", sb.deadlock); end
    tick();
    n_chk++; if (sb.deadlock !== 1'b1) begin n_fail++; $display("FAIL dl_set: got %b exp 1", sb.deadlock); end
    n_chk++; if (sb.rd_stall !== 2'b11) begin n_fail++; $display("FAIL dl_still_stall: got %b exp 11", sb.rd_stall); end
    idle();
    sb.wr_en = 1'b1; sb.wr_addr = 4'd4;
    #2;
    n_chk++; if (sb.wr_ok !== 1'b1) begin n_fail++; $display("FAIL dl_no_block: got wr_ok=%b exp 1", sb.wr_ok); end
    tick();
    idle();
    repeat (3) tick();
    n_chk++; if (sb.deadlock !== 1'b1) begin n_fail++; $display("FAIL dl_sticky: got %b exp 1", sb.deadlock); end
    do_reset();
    n_chk++; if (sb.deadlock !== 1'b0) begin n_fail++; $display("FAIL dl_cleared: got %b exp 0", sb.deadlock); end
  endtask

  task automatic test_read_consume();
    sb.wr_en = 1'b1; sb.wr_addr = 4'd5;
    #2;
    n_chk++; if (sb.wr_ok !== 1'b1) begin n_fail++; $display("FAIL rc_wr_ok: got %b exp 1", sb.wr_ok); end
    tick();
    idle();
    n_chk++; if (sb.valid_map[5] !== 1'b1) begin n_fail++; $display("FAIL rc_valid_set: got %b exp 1", sb.valid_map[5]); end
    n_chk++; if (sb.occupancy !== 5'd1) begin n_fail++; $display("FAIL rc_occ1: got %0d exp 1", sb.occupancy); end
    sb.rd_req = 2'b11; sb.rd_addr = {4'd5, 4'd5}; sb.rd_last = 2'b10;
    #2;
    n_chk++; if (sb.rd_ok !== 2'b11) begin n_fail++; $display("FAIL rc_rd_ok: got %b exp 11", sb.rd_ok); end
    tick();
    idle();
    n_chk++; if (sb.valid_map[5] !== 1'b0) begin n_fail++; $display("FAIL rc_valid_clr: got %b exp 0", sb.valid_map[5]); end
    n_chk++; if (sb.occupancy !== 5'd0) begin n_fail++; $display("FAIL rc_occ0: got %0d exp 0", sb.occupancy); end
  endtask

  task automatic test_forward();
    sb.wr_en = 1'b1; sb.wr_addr = 4'd7;
    sb.rd_req = 2'b01; sb.rd_addr = {4'd0, 4'd7};
    #2;
`ifdef SB_WR_FWD_EN
    n_chk++; if ({sb.rd_ok[0], sb.rd_stall[0]} !== 2'b10) begin n_fail++; $display("FAIL fwd_same: got ok=%b stall=%b exp 1/0", sb.rd_ok[0], sb.rd_stall[0]); end
`else
    n_chk++; if ({sb.rd_ok[0], sb.rd_stall[0]} !== 2'b01) begin n_fail++; $display("FAIL fwd_same: got ok=%b stall=%b exp 0/1", sb.rd_ok[0], sb.rd_stall[0]); end
`endif
    tick();
    sb.wr_en = 1'b0; sb.rd_last = 2'b01;
    #2;
    n_chk++; if (sb.rd_ok[0] !== 1'b1) begin n_fail++; $display("FAIL fwd_next: got %b exp 1", sb.rd_ok[0]); end
    tick();
    idle();
    n_chk++; if (sb.occupancy !== 5'd0) begin n_fail++; $display("FAIL fwd_occ: got %0d exp 0", sb.occupancy); end
    sb.wr_en = 1'b1; sb.wr_addr = 4'd8;
    sb.rd_req = 2'b10; sb.rd_addr = {4'd8, 4'd0}; sb.rd_last = 2'b10;
    #2;
`ifdef SB_WR_FWD_EN
    n_chk++; if (sb.rd_ok !== 2'b10) begin n_fail++; $display("FAIL fwd_last_ok: got %b exp 10", sb.rd_ok); end
    tick();
    idle();
    n_chk++; if (sb.valid_map[8] !== 1'b0 || sb.occupancy !== 5'd0) begin n_fail++; $display("FAIL fwd_last_state: got v8=%b occ=%0d exp 0/0", sb.valid_map[8], sb.occupancy); end
`else
    n_chk++; if (sb.rd_stall !== 2'b10) begin n_fail++; $display("FAIL fwd_last_ok: got stall=%b exp 10", sb.rd_stall); end
    tick();
    idle();
    n_chk++; if (sb.valid_map[8] !== 1'b1 || sb.occupancy !== 5'd1) begin n_fail++; $display("FAIL fwd_last_state: got v8=%b occ=%0d exp 1/1", sb.valid_map[8], sb.occupancy); end
`endif
  endtask

  task automatic test_full();
    do_reset();
    for (int a = 0; a < 16; a++) begin
      sb.wr_en = 1'b1; sb.wr_addr = 4'(a);
      #2;
      n_chk++; if (sb.wr_ok !== 1'b1) begin n_fail++; $display("FAIL fill_wr_ok[%0d]: got %b exp 1", a, sb.wr_ok); end
      tick();
    end
    idle();
    n_chk++; if (sb.occupancy !== 5'd16 || sb.valid_map !== 16'hFFFF) begin n_fail++; $display("FAIL full_state: got occ=%0d v=%h exp 16/ffff", sb.occupancy, sb.valid_map); end
    sb.wr_en = 1'b1; sb.wr_addr = 4'd2;
    #2;
    n_chk++; if ({sb.wr_ok, sb.wr_stall} !== 2'b01) begin n_fail++; $display("FAIL full_block: got ok=%b stall=%b exp 0/1", sb.wr_ok, sb.wr_stall); end
    tick();
    sb.rd_req = 2'b01; sb.rd_addr = {4'd0, 4'd2}; sb.rd_last = 2'b01;
    #2;
    n_chk++; if ({sb.wr_ok, sb.wr_stall, sb.rd_ok} !== 4'b1001) begin n_fail++; $display("FAIL full_swap: got ok=%b stall=%b rd_ok=%b exp 1/0/01", sb.wr_ok, sb.wr_stall, sb.rd_ok); end
    tick();
    idle();
    n_chk++; if (sb.valid_map[2] !== 1'b1 || sb.occupancy !== 5'd16) begin n_fail++; $display("FAIL full_swap_state: got v2=%b occ=%0d exp 1/16", sb.valid_map[2], sb.occupancy); end
  endtask

  task automatic test_dual_last();
    sb.rd_req = 2'b11; sb.rd_addr = {4'd9, 4'd9}; sb.rd_last = 2'b11;
    #2;
    n_chk++; if (sb.rd_ok !== 2'b11) begin n_fail++; $display("FAIL dual_ok: got %b exp 11", sb.rd_ok); end
    tick();
    idle();
    n_chk++; if (sb.occupancy !== 5'd15 || sb.valid_map !== 16'hFDFF) begin n_fail++; $display("FAIL dual_state: got occ=%0d v=%h exp 15/fdff", sb.occupancy, sb.valid_map); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int a = 0; a < 4; a++) begin
      sb.wr_en = 1'b1; sb.wr_addr = 4'(a * 3);
      tick();
    end
    idle();
    n_chk++; if (sb.occupancy !== 5'd4 || sb.valid_map !== 16'h0249) begin n_fail++; $display("FAIL mid_pre: got occ=%0d v=%h exp 4/0249", sb.occupancy, sb.valid_map); end
    sb.wr_en = 1'b1; sb.wr_addr = 4'd10; sb.rd_req = 2'b01; sb.rd_addr = {4'd0, 4'd3};
    rst_n = 1'b0;
    #2;
    n_chk++; if ({sb.wr_ok, sb.wr_stall, sb.rd_ok, sb.rd_stall} !== 6'b0) begin n_fail++; $display("FAIL mid_forced: got wr=%b%b rd=%b%b exp all 0", sb.wr_ok, sb.wr_stall, sb.rd_ok, sb.rd_stall); end
    tick();
    n_chk++; if (sb.valid_map !== 16'h0 || sb.occupancy !== 5'd0 || sb.deadlock !== 1'b0) begin n_fail++; $display("FAIL mid_state: got v=%h occ=%0d dl=%b exp 0/0/0", sb.valid_map, sb.occupancy, sb.deadlock); end
    n_chk++; if (sb.wr_ok !== 1'b0) begin n_fail++; $display("FAIL mid_wr_ok: got %b exp 0", sb.wr_ok); end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_deadlock();
    test_read_consume();
    test_forward();
    test_full();
    test_dual_last();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stall_scoreboard.md
Name: stall_scoreboard

Overview:
Parametrised multi-channel hazard/stall unit for a PE scratchpad buffer.
- Keeps a per-entry valid bit (producer written, consumer not yet finished) for every address of a 2^CONFIG_BIT-entry buffer.
- Grants or stalls one write port and NUM_RD read ports each cycle.
- Tracks occupancy and flags deadlock when a channel stalls too long.
- Sits between the PE write-back stage and the PE operand-fetch stages.

Parameters:
CONFIG_BIT, 4, address width; buffer depth DEPTH = 2^CONFIG_BIT
NUM_RD, 2, number of independent read channels (>=1)
TIMEOUT_W, 8, width of per-channel stall counter; deadlock limit = 2^TIMEOUT_W-1 consecutive stall cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
wr_en  input  1  producer requests write of entry wr_addr
wr_addr  input  CONFIG_BIT  write address
rd_req  input  NUM_RD  per-channel read request
rd_addr  input  NUM_RD*CONFIG_BIT  packed read addresses; channel i at [i*CONFIG_BIT +: CONFIG_BIT]
rd_last  input  NUM_RD  per-channel: this read is the final consumer of the entry; clears valid when granted
wr_ok  output  1  write granted this cycle
wr_stall  output  1  write requested but blocked
rd_ok  output  NUM_RD  read granted per channel
rd_stall  output  NUM_RD  read requested but blocked per channel
valid_map  output  DEPTH  registered valid bits
occupancy  output  CONFIG_BIT+1  registered count of valid entries, 0..DEPTH
deadlock  output  1  sticky; set when any channel's stall counter reaches limit

Behaviour:
- Reset (rst_n=0 at posedge):
  - valid_map=0, occupancy=0, all stall counters=0, deadlock=0.
  - While rst_n=0, combinational grants are forced: wr_ok=0, wr_stall=0, rd_ok=0, rd_stall=0.
- Read hit, channel i: hit_i = valid[rd_addr_i].
  - rd_ok[i] = rd_req[i] & hit_i.
  - rd_stall[i] = rd_req[i] & ~hit_i.
  - No request gives both 0.
- Clear: clr_vec = OR over granted channels with rd_last of onehot(rd_addr_i).
  - Several channels clearing the same address clear it once.
- Write grant:
  - wr_ok = wr_en & (~valid[wr_addr] | clr_vec[wr_addr]); a same-cycle consume frees the slot.
  - wr_stall = wr_en & ~wr_ok.
- Next state: valid_next = (valid & ~clr_vec) | (wr_ok ? onehot(wr_addr) : 0). Set wins over clear on the same address.
- occupancy_next = occupancy - popcount(clr_vec) + wr_ok. The result never exceeds DEPTH or goes below 0 by construction.
- All grant/stall outputs are combinational from current inputs and registered state, with zero-cycle latency. A granted write is visible to reads on the next cycle.
- Full: all valid means every write stalls unless a same-cycle clear hits wr_addr.
- Empty: every read stalls.
- Stall counter per channel:
  - Increments (saturating at 2^TIMEOUT_W-1) on each cycle with rd_stall[i]=1.
  - Resets to 0 on any cycle the channel is not stalled.
- deadlock goes to 1 the cycle after any counter reaches the limit. It stays 1 until reset and does not block grants.
- Reset mid-operation: all state is discarded on the first posedge with rst_n=0, and pending requests are dropped.

Optional Feature:
Macro SB_WR_FWD_EN.
- Defined: hit_i = valid[rd_addr_i] | (wr_ok & wr_addr==rd_addr_i), so a same-cycle write forwards to readers.
  - If a forwarded read also asserts rd_last, the entry is consumed immediately: valid stays 0 and occupancy is unchanged.
  - The forwarded clear does not feed back into wr_ok; no combinational loop.
- Undefined: hit uses registered valid only, and the read stalls for one cycle.

Test Plan:
- Reset, then rd_req=2'b11 on addr 3 -> rd_stall=2'b11, rd_ok=0; after 255 stall cycles (TIMEOUT_W=8) deadlock=1 on the next cycle and stays 1 until rst_n=0.
- Write addr 5, next cycle ch0 read addr 5 with rd_last=0 and ch1 with rd_last=1 -> both rd_ok=1; valid_map[5] goes 1 then 0; occupancy goes 0->1->0.
- Fill all 16 entries -> occupancy=16; write addr 2 -> wr_stall=1; repeat with same-cycle ch0 rd_last on addr 2 -> wr_ok=1, valid_map[2] stays 1, occupancy stays 16.
- Same cycle, write addr 7 with ch0 reading addr 7 (empty): without SB_WR_FWD_EN -> rd_stall[0]=1, read granted next cycle; with SB_WR_FWD_EN -> rd_ok[0]=1 in the same cycle.
- Both channels rd_last on valid addr 9 in the same cycle -> occupancy decrements by exactly 1.
- Assert rst_n=0 with 4 entries valid and a write pending -> next cycle valid_map=0, occupancy=0, deadlock=0; wr_ok=0 while in reset.
